// File: rtl/scalar_product_pkg.sv
// Shared types and width helpers for the scalar product controller.
// Holds the FSM state enum plus dot and pass-counter width functions.
package scalar_product_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int dot_w(int nbits, int ndata);
    return 2*nbits + $clog2(ndata);
  endfunction

  function automatic int pass_w(int ndata, int nlanes);
    return $clog2(ndata/nlanes) + 1;
  endfunction

endpackage

// File: rtl/scalar_product_ctrl_lane_sum.sv
// lane_sum: combinational sum of Nlanes unsigned 2*Nbits products.
// Ports: p (packed lane products in), sum (widened total out).
module lane_sum #(
  parameter int Nbits  = 4,
  parameter int Nlanes = 4
) (
  input  logic [Nlanes*2*Nbits-1:0]         p,
  output logic [2*Nbits+$clog2(Nlanes)-1:0] sum
);

  localparam int LW = 2*Nbits + $clog2(Nlanes);

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    sum = '0;
    for (int j = 0; j < Nlanes; j++) begin
      sum = sum + LW'(p[j*2*Nbits +: 2*Nbits]);
    end
  end

endmodule

// File: rtl/scalar_product_ctrl.sv
// Time-multiplexes an external Nlanes multiplier over two Ndata vectors.
// Ports: in handshake + a_vec/b_vec, mul_* to multiplier, out handshake + prod_vec/dot, busy.
module scalar_product_ctrl
  import scalar_product_pkg::*;
#(
  parameter int Nbits  = 4,
  parameter int Ndata  = 8,
  parameter int Nlanes = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Ndata*Nbits-1:0]           a_vec,
  input  logic [Ndata*Nbits-1:0]           b_vec,
  output logic [Nlanes*Nbits-1:0]          mul_a,
  output logic [Nlanes*Nbits-1:0]          mul_b,
  input  logic [Nlanes*2*Nbits-1:0]        mul_p,
  output logic [Ndata*2*Nbits-1:0]         prod_vec,
  output logic [dot_w(Nbits,Ndata)-1:0]    dot,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam int P   = Ndata / Nlanes;
  localparam int PW  = pass_w(Ndata, Nlanes);
  localparam int DW  = dot_w(Nbits, Ndata);
  localparam int LW  = 2*Nbits + $clog2(Nlanes);
  localparam int SA  = Nlanes * Nbits;
  localparam int SP  = Nlanes * 2 * Nbits;
  localparam int PVW = Ndata * 2 * Nbits;

  state_t                 state;
  state_t                 state_nxt;
  logic [Ndata*Nbits-1:0] a_sh;
  logic [Ndata*Nbits-1:0] b_sh;
  logic [PW-1:0]          pass;
  logic [LW-1:0]          lsum;
  logic                   last;

  lane_sum #(
    .Nbits  (Nbits),
    .Nlanes (Nlanes)
  ) u_lane_sum (
    .p   (mul_p),
    .sum (lsum)
  );

  assign last = (pass == PW'(P-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    mul_a     = '0;
    mul_b     = '0;
    if (state == RUN) begin
      mul_a = a_sh[SA-1:0];
      mul_b = b_sh[SA-1:0];
    end
  end

  // New products enter at the top so slice 0 ends at the bottom.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      prod_vec <= '0;
      dot      <= '0;
      pass     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a_vec;
            b_sh     <= b_vec;
            prod_vec <= '0;
            dot      <= '0;
            pass     <= '0;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> SA;
          b_sh     <= b_sh >> SA;
          prod_vec <= (prod_vec >> SP)
                    | (PVW'(mul_p) << (PVW - SP));
          dot      <= dot + DW'(lsum);
          pass     <= pass + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_product_ctrl.sv
// Directed bench for scalar_product_ctrl with a behavioural multiplier.
// Covers reset, reference, max, backpressure, back-to-back, mid-run reset, single pass.
module tb_scalar_product_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a_vec, b_vec;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic [63:0] prod_vec;
  logic [10:0] dot;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [31:0] a_vec2, b_vec2;
  logic [31:0] mul_a2, mul_b2;
  logic [63:0] mul_p2;
  logic [63:0] prod_vec2;
  logic [10:0] dot2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar j = 0; j < 4; j++) begin : g_mul
    assign mul_p[j*8 +: 8] = mul_a[j*4 +: 4] * mul_b[j*4 +: 4];
  end

  for (genvar j = 0; j < 8; j++) begin : g_mul2
    assign mul_p2[j*8 +: 8] = mul_a2[j*4 +: 4] * mul_b2[j*4 +: 4];
  end

  scalar_product_ctrl #(.Nbits(4), .Ndata(8), .Nlanes(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .prod_vec  (prod_vec),
    .dot       (dot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  scalar_product_ctrl #(.Nbits(4), .Ndata(8), .Nlanes(8)) dut1p (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a_vec     (a_vec2),
    .b_vec     (b_vec2),
    .mul_a     (mul_a2),
    .mul_b     (mul_b2),
    .mul_p     (mul_p2),
    .prod_vec  (prod_vec2),
    .dot       (dot2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .busy      (busy2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] REF_A = 32'h76543210;
  localparam logic [31:0] REF_B = 32'h01234567;
  localparam logic [63:0] REF_P = 64'h00060A0C0C0A0600;
  localparam logic [63:0] MAX_P = 64'hE1E1E1E1E1E1E1E1;
  localparam logic [31:0] P2_A  = 32'h12345678;
  localparam logic [31:0] P2_B  = 32'h87654321;
  localparam logic [63:0] P2_P  = 64'h080E121414120E08;

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a_vec      = '0;
    b_vec      = '0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b0;
    a_vec2     = '0;
    b_vec2     = '0;

    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dot", dot, 0);
    chk("rst_prod", prod_vec, 0);
    chk("rst_mul_a", mul_a, 0);
    reset_n = 1'b1;
    step();

    // Reference vector plus backpressure
    in_valid = 1'b1;
    a_vec    = REF_A;
    b_vec    = REF_B;
    step();
    in_valid = 1'b0;
    chk("ref_busy", busy, 1);
    chk("ref_in_ready", in_ready, 0);
    chk("ref_mul_a0", mul_a, 16'h3210);
    chk("ref_mul_b0", mul_b, 16'h4567);
    step();
    chk("ref_not_yet", out_valid, 0);
    chk("ref_mul_a1", mul_a, 16'h7654);
    step();
    chk("ref_out_valid", out_valid, 1);
    chk("ref_dot", dot, 56);
    chk("ref_prod", prod_vec, REF_P);
    chk("ref_mul_idle", mul_a, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_dot", dot, 56);
      chk("bp_prod", prod_vec, REF_P);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    // Maximum operands
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_vec     = 32'hFFFFFFFF;
    b_vec     = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("max_valid", out_valid, 1);
    chk("max_dot", dot, 1800);
    chk("max_prod", prod_vec, MAX_P);
    step();
    chk("max_done_ready", in_ready, 1);

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    a_vec    = 32'h11111111;
    b_vec    = 32'h22222222;
    step();
    a_vec = P2_A;
    b_vec = P2_B;
    step();
    step();
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_dot1", dot, 16);
    chk("b2b_prod1", prod_vec, 64'h0202020202020202);
    step();
    chk("b2b_gap_ready", in_ready, 1);
    chk("b2b_gap_busy", busy, 0);
    step();
    in_valid = 1'b0;
    chk("b2b_accept2", busy, 1);
    step();
    step();
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_dot2", dot, 120);
    chk("b2b_prod2", prod_vec, P2_P);
    step();

    // Reset mid-RUN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_vec     = REF_A;
    b_vec     = REF_B;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_busy", busy, 1);
    chk("mid_dot_partial", dot, 28);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_dot", dot, 0);
    chk("mid_rst_prod", prod_vec, 0);
    reset_n = 1'b1;
    step();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_vec     = P2_A;
    b_vec     = P2_B;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_dot", dot, 120);
    chk("post_rst_prod", prod_vec, P2_P);
    step();
    out_ready = 1'b0;

    // Single-pass configuration
    in_valid2 = 1'b1;
    a_vec2    = REF_A;
    b_vec2    = REF_B;
    step();
    in_valid2 = 1'b0;
    chk("sp_run_valid", out_valid2, 0);
    chk("sp_mul_a", mul_a2, REF_A);
    step();
    chk("sp_valid", out_valid2, 1);
    chk("sp_dot", dot2, 56);
    chk("sp_prod", prod_vec2, REF_P);
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    chk("sp_ready", in_ready2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_product_ctrl.md
# scalar_product_ctrl

Sequencing controller that computes the elementwise products and the dot product of two Ndata-element unsigned vectors by time-multiplexing one shared, purely combinational `multiply` instance of Nlanes lanes. It accepts an operand pair over a valid/ready handshake. It feeds Nlanes-element slices to the multiplier, one slice per cycle, least-significant slice first. Per-lane products are gathered into a product vector and summed into a scalar accumulator. The block sits between the operand loader and the matmul result path; the `multiply` instance is external, wired to the `mul_*` ports.

## Interface
- Nbits, 4, element width in bits (unsigned)
- Ndata, 8, elements per input vector
- Nlanes, 4, lanes of the shared multiplier; Ndata must be an integer multiple of Nlanes
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- a_vec  in  Ndata*Nbits  operand A; element i at [i*Nbits +: Nbits]
- b_vec  in  Ndata*Nbits  operand B, same packing
- mul_a  out  Nlanes*Nbits  to multiplier `multiplier` port
- mul_b  out  Nlanes*Nbits  to multiplier `multiplicand` port
- mul_p  in  Nlanes*2*Nbits  from multiplier `mult_out`; lane j at [j*2*Nbits +: 2*Nbits]
- prod_vec  out  Ndata*2*Nbits  elementwise products; element i at [i*2*Nbits +: 2*Nbits]
- dot  out  2*Nbits+$clog2(Ndata)  sum of all products
- out_valid  out  1  prod_vec/dot valid
- out_ready  in  1  consumer accepts the result
- busy  out  1  high whenever state is not IDLE

## Operation
- Constant P = Ndata/Nlanes is the number of passes. The pass counter is $clog2(P)+1 bits wide.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture a_vec/b_vec into shift registers a_sh/b_sh.
  - Clear prod_vec, dot and pass to 0, then go to RUN.
- RUN:
  - mul_a = a_sh[Nlanes*Nbits-1:0] and mul_b = b_sh[...] (combinational from registers). mul_p is sampled in the same cycle.
  - Each edge shifts a_sh/b_sh right by Nlanes*Nbits.
  - Each edge shifts prod_vec right by Nlanes*2*Nbits with mul_p inserted at the top. After P passes, slice k sits at element positions k*Nlanes..k*Nlanes+Nlanes-1.
  - Each edge does dot += lane_sum(mul_p) and pass += 1.
  - When pass==P-1, go to DONE.
- DONE:
  - out_valid=1; prod_vec and dot are held stable.
  - When out_ready is high, go to IDLE.
- in_ready is low in RUN and DONE; in_valid is ignored there.
- mul_a and mul_b are forced to 0 outside RUN.
- Arithmetic is unsigned with no overflow. The dot width holds Ndata*(2^Nbits-1)^2 exactly; the lane sum is zero-extended before accumulation.
- Reset, including when asserted mid-RUN or mid-DONE:
  - State goes immediately to IDLE.
  - in_ready=1, and out_valid, busy, mul_a, mul_b, prod_vec, dot and pass all go to 0.
  - The partial result is discarded.

## Timing
- Accept edge t: the edge where in_valid && in_ready.
- RUN covers edges t+1..t+P. out_valid rises after edge t+P, i.e. P cycles after acceptance.
- Result handshake: completes on the edge where out_valid && out_ready. in_ready is high again the next cycle, so the minimum initiation interval is P+2 cycles.
- Stalling: out_ready held low stalls the block indefinitely in DONE with no change to its outputs.
- The multiplier path is combinational within one cycle. The timing path is mul_a → multiply → lane_sum → dot register.

## Structure
- Package scalar_product_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the width helper functions: dot width and pass-counter width.
- Sub-module `lane_sum`: a combinational adder tree over Nlanes products of 2*Nbits, producing a 2*Nbits+$clog2(Nlanes)-bit output. It is reused by the future row-accumulator.
- The `multiply` instance is not instantiated inside this block. The testbench and top level connect it.

## Test plan
- **Reference vector.** Stimulus: a_vec element i = i, b_vec element i = 7-i (Ndata=8, Nlanes=4). Required: prod_vec elements = 0,6,10,12,12,10,6,0; dot=56; out_valid 2 cycles after accept.
- **Maximum operands.** Stimulus: all elements 15. Required: every prod_vec element = 225, dot=1800, no truncation.
- **Backpressure.** Stimulus: out_ready held low for 5 cycles. Required: out_valid, prod_vec and dot stay stable; in_ready stays 0; release completes the handshake with in_ready=1 on the next cycle.
- **Back-to-back.** Stimulus: in_valid held high with two distinct vector pairs. Required: the second is accepted exactly one cycle after the first result handshake; both dot values are correct.
- **Reset mid-RUN.** Stimulus: reset_n pulsed low after the first pass. Required: outputs go to 0 and in_ready=1 asynchronously; the next operand pair computes correctly from scratch.
- **Single-pass configuration.** Stimulus: Nlanes=Ndata=8 with the reference vector. Required: out_valid 1 cycle after accept; dot=56.
